// File: rtl/ci_collect_pkg.sv
// ci_collect_pkg: FSM states, code bit positions and the expected pixel count
// shared by ci_joint_collector and its bench.
package ci_collect_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_DRAIN, ST_DONE} state_t;
  localparam int R2_BIT = 0;
  localparam int R4_BIT = 1;
  localparam int R6_BIT = 2;
  localparam int R8_BIT = 3;
  localparam int NRAD = 4;
  function automatic int npix(input int rows, input int cols);
    return (rows - 16) * (cols - 16);
  endfunction
endpackage

// File: rtl/ci_bit_fifo.sv
// ci_bit_fifo: 1-bit alignment FIFO; pointers carry an extra wrap bit so full
// and empty are distinguishable, and a full FIFO accepts a push on a pop edge.
module ci_bit_fifo #(
  parameter int DEPTH = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_push,
  input  logic i_din,
  input  logic i_pop,
  output logic o_dout,
  output logic o_empty,
  output logic o_drop
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] r_wr;
  logic [AW:0] r_rd;
  logic [DEPTH-1:0] r_mem;
  logic w_full;
  logic w_wr;
  assign o_empty = r_wr == r_rd;
  assign w_full = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_wr = i_push && (!w_full || i_pop);
  assign o_drop = i_push && w_full && !i_pop;
  assign o_dout = r_mem[r_rd[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_wr) r_wr <= r_wr + 1'b1;
      if (i_pop && !o_empty) r_rd <= r_rd + 1'b1;
    end
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wr[AW-1:0]] <= i_din;
endmodule

// File: rtl/ci_joint_collector.sv
// ci_joint_collector: aligns four per-radius CI bit streams into 4-bit joint codes
// and tracks frame end. Define CI_COLLECT_CHECK_EN to add the per-frame count_err_o check.
module ci_joint_collector
  import ci_collect_pkg::*;
#(
  parameter int ROWS = 30,
  parameter int COLS = 30,
  parameter int FIFO_DEPTH = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ci_r2_i,
  input  logic       ci_r4_i,
  input  logic       ci_r6_i,
  input  logic       ci_r8_i,
  input  logic       done_r2_i,
  input  logic       done_r4_i,
  input  logic       done_r6_i,
  input  logic       done_r8_i,
  input  logic       progress_done_r2_i,
  input  logic       progress_done_r4_i,
  input  logic       progress_done_r6_i,
  input  logic       progress_done_r8_i,
  output logic [3:0] code_o,
  output logic       valid_o,
  output logic       frame_done_o,
  output logic       overflow_o
`ifdef CI_COLLECT_CHECK_EN
  ,
  output logic       count_err_o
`endif
);
  state_t r_state;
  logic [NRAD-1:0] r_flag;
  logic [NRAD-1:0] w_ci;
  logic [NRAD-1:0] w_done;
  logic [NRAD-1:0] w_prog;
  logic [NRAD-1:0] w_dout;
  logic [NRAD-1:0] w_empty;
  logic [NRAD-1:0] w_drop;
  logic w_pop;
  logic w_end;
  assign w_ci[R2_BIT] = ci_r2_i;
  assign w_ci[R4_BIT] = ci_r4_i;
  assign w_ci[R6_BIT] = ci_r6_i;
  assign w_ci[R8_BIT] = ci_r8_i;
  assign w_done[R2_BIT] = done_r2_i;
  assign w_done[R4_BIT] = done_r4_i;
  assign w_done[R6_BIT] = done_r6_i;
  assign w_done[R8_BIT] = done_r8_i;
  assign w_prog[R2_BIT] = progress_done_r2_i;
  assign w_prog[R4_BIT] = progress_done_r4_i;
  assign w_prog[R6_BIT] = progress_done_r6_i;
  assign w_prog[R8_BIT] = progress_done_r8_i;
  for (genvar k = 0; k < NRAD; k++) begin : g_fifo
    ci_bit_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_push (w_done[k]),
      .i_din  (w_ci[k]),
      .i_pop  (w_pop),
      .o_dout (w_dout[k]),
      .o_empty(w_empty[k]),
      .o_drop (w_drop[k])
    );
  end
  // A pixel leaves only when every radius has contributed its bit.
  assign w_pop = ~|w_empty;
  assign w_end = (r_state == ST_DRAIN) && (&w_empty) && !w_pop;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_flag <= '0;
      code_o <= '0;
      valid_o <= 1'b0;
      frame_done_o <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      valid_o <= w_pop;
      if (w_pop) code_o <= w_dout;
      frame_done_o <= w_end;
      overflow_o <= overflow_o || (|w_drop);
      r_flag <= (r_state == ST_DONE ? '0 : r_flag) | w_prog;
      case (r_state)
        ST_IDLE:    if (|w_done) r_state <= ST_COLLECT;
        ST_COLLECT: if (&r_flag) r_state <= ST_DRAIN;
        ST_DRAIN:   if (w_end) r_state <= ST_DONE;
        default:    r_state <= ST_IDLE;
      endcase
    end
`ifdef CI_COLLECT_CHECK_EN
  localparam int NPIX = npix(ROWS, COLS);
  localparam int CW = $clog2(ROWS * COLS + 2) + 1;
  logic [CW-1:0] r_cnt;
  // Saturating so an oversized frame can never wrap back onto NPIX.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt <= '0;
      count_err_o <= 1'b0;
    end else begin
      r_cnt <= w_end ? '0 : r_cnt + CW'(w_pop && !(&r_cnt));
      count_err_o <= w_end && (r_cnt != CW'(NPIX));
    end
`endif
endmodule

// File: tb/tb_ci_joint_collector.sv
// tb_ci_joint_collector: randomized directed sequence against a queue-based model
// of per-radius bit streams; pixel k pairs the k-th bit pushed on each radius.
`timescale 1ns/1ps
module tb_ci_joint_collector;
  import ci_collect_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  logic [3:0] ci, done, prog;
  logic [3:0] code;
  logic valid, fd, ovf;
  logic d4_done2, d4_ci2, d4_dr;
  logic [2:0] d4_ct;
  logic [3:0] code4;
  logic valid4, fd4, ovf4;
`ifdef CI_COLLECT_CHECK_EN
  logic cerr, cerr4;
`endif
  int n_tests = 0, n_fail = 0, n_valid = 0, n_fd = 0, sent_pix = 0;
  bit q[4][$];
  time last_valid_t = 0;
  logic [3:0] m_exp;

  ci_joint_collector dut (
    .clk(clk), .rst_n(rst_n),
    .ci_r2_i(ci[0]), .ci_r4_i(ci[1]), .ci_r6_i(ci[2]), .ci_r8_i(ci[3]),
    .done_r2_i(done[0]), .done_r4_i(done[1]), .done_r6_i(done[2]), .done_r8_i(done[3]),
    .progress_done_r2_i(prog[0]), .progress_done_r4_i(prog[1]),
    .progress_done_r6_i(prog[2]), .progress_done_r8_i(prog[3]),
    .code_o(code), .valid_o(valid), .frame_done_o(fd), .overflow_o(ovf)
`ifdef CI_COLLECT_CHECK_EN
    , .count_err_o(cerr)
`endif
  );

  ci_joint_collector #(.FIFO_DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .ci_r2_i(d4_ci2), .ci_r4_i(d4_ct[0]), .ci_r6_i(d4_ct[1]), .ci_r8_i(d4_ct[2]),
    .done_r2_i(d4_done2), .done_r4_i(d4_dr), .done_r6_i(d4_dr), .done_r8_i(d4_dr),
    .progress_done_r2_i(1'b0), .progress_done_r4_i(1'b0),
    .progress_done_r6_i(1'b0), .progress_done_r8_i(1'b0),
    .code_o(code4), .valid_o(valid4), .frame_done_o(fd4), .overflow_o(ovf4)
`ifdef CI_COLLECT_CHECK_EN
    , .count_err_o(cerr4)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] d, input logic [3:0] b, input logic [3:0] p);
    done = d;
    ci = b;
    prog = p;
    for (int k = 0; k < 4; k++) if (d[k]) q[k].push_back(b[k]);
    step();
    done = '0;
    ci = '0;
    prog = '0;
  endtask

  task automatic wait_fd(input string tag, input int exp);
    for (int i = 0; i < 60 && n_fd < exp; i++) begin
      @(negedge clk);
      #1;
    end
    chk(tag, n_fd, exp);
  endtask

  task automatic send_frame(input int n);
    sent_pix += n;
    for (int i = 0; i < n; i++) drive(4'hF, 4'($urandom), (i == n - 1) ? 4'hF : 4'h0);
  endtask

  always @(negedge clk) if (rst_n) begin
    if (valid) begin
      n_valid++;
      last_valid_t = $time;
      if (q[0].size() > 0 && q[1].size() > 0 && q[2].size() > 0 && q[3].size() > 0) begin
        for (int k = 0; k < 4; k++) m_exp[k] = q[k].pop_front();
        chk("code", code, m_exp);
      end else chk("unexpected_valid", valid, 0);
    end
    if (fd) begin
      n_fd++;
      chk("fd_after_last_valid", last_valid_t < $time, 1);
`ifdef CI_COLLECT_CHECK_EN
      chk("count_err", cerr, sent_pix != npix(30, 30));
`endif
      sent_pix = 0;
    end
`ifdef CI_COLLECT_CHECK_EN
    else chk("count_err_idle", cerr, 0);
`endif
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int v0, f0;
    int off[4];
    logic [3:0] d, b, p;
    logic [5:0] r2bits;
    logic [3:0] exp4[4];
    logic [3:0] got4[$];
    logic [2:0] t;
    rst_n = 1'b0; ci = '0; done = '0; prog = '0;
    d4_done2 = 0; d4_ci2 = 0; d4_dr = 0; d4_ct = '0;
    repeat (3) @(negedge clk);
    chk("rst_code", code, 0);
    chk("rst_valid", valid, 0);
    chk("rst_fd", fd, 0);
    chk("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    step();
    // aligned pixel: r2=1 r4=0 r6=1 r8=1
    drive(4'hF, 4'b1101, 4'h0);
    sent_pix += 1;
    @(negedge clk);
    chk("align_not_yet", valid, 0);
    @(negedge clk);
    chk("align_valid", valid, 1);
    chk("align_code", code, 4'b1101);
    @(negedge clk);
    chk("align_valid_drop", valid, 0);
    chk("align_code_hold", code, 4'b1101);
    // skewed streams: r8 trails r2 by 40 cycles
    v0 = n_valid; f0 = n_fd;
    off = '{0, 10, 20, 40};
    for (int c = 0; c < 140; c++) begin
      d = '0;
      for (int k = 0; k < 4; k++) d[k] = (c >= off[k]) && (c < off[k] + 100);
      drive(d, 4'($urandom), 4'h0);
    end
    sent_pix += 100;
    repeat (10) @(negedge clk);
    chk("skew_count", n_valid - v0, 100);
    chk("skew_ovf", ovf, 0);
    chk("skew_no_fd", n_fd, f0);
    // frame end: progress pulses land on each stream's last bit, r2 first
    v0 = n_valid;
    off = '{0, 3, 6, 9};
    for (int c = 0; c < 29; c++) begin
      d = '0; p = '0;
      for (int k = 0; k < 4; k++) begin
        d[k] = (c >= off[k]) && (c < off[k] + 20);
        p[k] = (c == off[k] + 19);
      end
      drive(d, 4'($urandom), p);
    end
    sent_pix += 20;
    wait_fd("frame_fd", f0 + 1);
    chk("frame_count", n_valid - v0, 20);
    repeat (10) @(negedge clk);
    chk("frame_single_fd", n_fd, f0 + 1);
    // overflow on depth-4 instance
    r2bits = 6'($urandom);
    for (int i = 0; i < 6; i++) begin
      d4_done2 = 1; d4_ci2 = r2bits[i];
      step();
      d4_done2 = 0;
      @(negedge clk);
      chk($sformatf("ovf_after_push%0d", i + 1), ovf4, i >= 4);
    end
    chk("ovf_main_clear", ovf, 0);
    for (int i = 0; i < 4; i++) begin
      t = 3'($urandom);
      exp4[i] = {t, r2bits[i]};
      d4_dr = 1; d4_ct = t;
      step();
      d4_dr = 0;
      @(negedge clk);
      if (valid4) got4.push_back(code4);
    end
    repeat (4) begin
      @(negedge clk);
      if (valid4) got4.push_back(code4);
    end
    chk("ovf_retained", got4.size(), 4);
    for (int i = 0; i < 4 && i < got4.size(); i++) chk($sformatf("ovf_code%0d", i), got4[i], exp4[i]);
    // reset mid-frame with three r2 bits queued
    for (int i = 0; i < 3; i++) drive(4'b0001, 4'($urandom), 4'h0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_code", code, 0);
    chk("midrst_valid", valid, 0);
    chk("midrst_fd", fd, 0);
    chk("midrst_ovf4", ovf4, 0);
    for (int k = 0; k < 4; k++) q[k].delete();
    sent_pix = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    v0 = n_valid; f0 = n_fd;
    drive(4'b1110, 4'($urandom), 4'h0);
    repeat (5) @(negedge clk);
    chk("midrst_no_stale", n_valid - v0, 0);
    drive(4'b0001, 4'($urandom), 4'h0);
    sent_pix += 1;
    repeat (4) @(negedge clk);
    chk("midrst_clean", n_valid - v0, 1);
    // frames sized around NPIX
    send_frame(5);
    wait_fd("fd_small", f0 + 1);
    send_frame(195);
    wait_fd("fd_195", f0 + 2);
    send_frame(196);
    wait_fd("fd_196", f0 + 3);
    repeat (5) @(negedge clk);
    chk("final_ovf", ovf, 0);
    chk("final_queues_empty", q[0].size() + q[1].size() + q[2].size() + q[3].size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ci_joint_collector.md
CI_JOINT_COLLECTOR -- requirements
Module: ci_joint_collector

Interface
REQ-001 SHALL have parameter ROWS, default 30, image rows.
REQ-002 SHALL have parameter COLS, default 30, image columns.
REQ-003 SHALL have parameter FIFO_DEPTH, default 64, entries per radius alignment FIFO; power of two, at least 2.
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have ports ci_rK_i, input, 1, CI bit for radius K, for K = 2, 4, 6, 8.
REQ-007 SHALL have ports done_rK_i, input, 1, ci_rK_i valid strobe, for K = 2, 4, 6, 8.
REQ-008 SHALL have ports progress_done_rK_i, input, 1, end-of-frame pulse for radius K, for K = 2, 4, 6, 8.
REQ-009 SHALL have port code_o, output, 4, joint CI code: bit0=r2, bit1=r4, bit2=r6, bit3=r8.
REQ-010 SHALL have port valid_o, output, 1, code_o valid, one cycle per pixel.
REQ-011 SHALL have port frame_done_o, output, 1, single-cycle end-of-frame pulse.
REQ-012 SHALL have port overflow_o, output, 1, sticky flag: an alignment FIFO dropped a bit.

Function
REQ-013 SHALL push ci_rK_i into FIFO K on every cycle that done_rK_i=1, independently per radius.
REQ-014 SHALL pop all four FIFOs together on a cycle when all four are non-empty; no partial pop.
REQ-015 SHALL register the popped bits to code_o with valid_o=1 on the cycle after the pop edge.
REQ-016 SHALL make a bit pushed at edge t poppable no earlier than edge t+1; minimum push-to-valid_o latency is 2 cycles.
REQ-017 SHALL accept a push to a full FIFO when a pop of that FIFO occurs on the same edge.
REQ-018 SHALL drop a push to a full FIFO with no same-edge pop, and set overflow_o until reset.
REQ-019 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH; full/empty SHALL be resolved with an extra pointer bit.
REQ-020 SHALL latch each progress_done_rK_i pulse in a per-radius flag; a pulse coinciding with its final done_rK_i SHALL still push that bit.
REQ-021 SHALL implement a 4-state FSM:
- IDLE -> COLLECT on any done_rK_i.
- COLLECT -> DRAIN when all four flags are set.
- DRAIN -> DONE when all FIFOs are empty and no pop is pending.
- DONE -> IDLE unconditionally.
REQ-022 SHALL assert frame_done_o only during DONE, for exactly one cycle, after the last valid_o of the frame; DONE SHALL clear all four flags.
REQ-023 SHALL push a done_rK_i arriving in DRAIN or DONE into its FIFO as next-frame data, without affecting the current frame_done_o.
REQ-024 SHALL keep code_o at its last value while valid_o=0.

Reset
REQ-025 SHALL, on rst_n=0, immediately clear code_o=0, valid_o=0, frame_done_o=0 and overflow_o=0, empty all FIFOs, clear all flags and enter IDLE, including mid-frame.
REQ-026 SHALL resume on the first rising clk edge after rst_n deasserts.

Configuration
REQ-027 SHALL, with macro CI_COLLECT_CHECK_EN defined, add output count_err_o (1 bit, reset 0), set for one cycle with frame_done_o when the frame's valid_o count differs from (ROWS-16)*(COLS-16).
REQ-028 SHALL, without CI_COLLECT_CHECK_EN, omit count_err_o and the pixel counter entirely.

Structure
REQ-029 SHALL place the FSM state enum, the code bit-index constants (R2_BIT=0 .. R8_BIT=3) and the NPIX expression in package ci_collect_pkg.
REQ-030 SHALL implement each per-radius FIFO as one instance of sub-module ci_bit_fifo (1-bit wide, parameter DEPTH); there SHALL be four instances.

Verification
REQ-031 SHALL verify aligned timing: all four done_rK_i high at cycle 10 with bits 1,0,1,1 -> valid_o=1 at cycle 12, code_o=4'b1101.
REQ-032 SHALL verify skewed streams: r2 bits leading r8 by 40 cycles, 100 pixels -> exactly 100 valid_o pulses, codes in order, overflow_o=0.
REQ-033 SHALL verify overflow: FIFO_DEPTH=4, 6 r2 pushes with no r8 data -> overflow_o=1 after the 5th push, 4 entries retained.
REQ-034 SHALL verify frame end: progress pulses in order r2, r4, r6, r8, last one at cycle 500 -> one frame_done_o pulse after the final valid_o.
REQ-035 SHALL verify reset mid-frame: rst_n low at cycle 200 with 3 entries queued -> no valid_o after reset; next frame codes start clean.
REQ-036 SHALL verify the check option: with CI_COLLECT_CHECK_EN, ROWS=COLS=30 and 195 pixels -> count_err_o=1 together with frame_done_o; with 196 pixels -> count_err_o=0.
